data_mem: RTL and testbench

//  - Single-port word-organised data memory for the single-cycle/pipelined CPU datapath (MEM stage).
//  - Byte address in; word-aligned access; synchronous write, combinational (asynchronous) read.
//  - Sits between ALU result (address) / register-file rs2 data (write data) and the writeback mux.

---
 rtl/data_mem.sv | 83 ++++++++
 tb/tb_data_mem.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//   Word-organised data memory for the CPU MEM stage. It takes a byte address
//   and performs word-granular accesses. Writes are synchronous and reads are
//   combinational. rst_n asynchronously clears every word to zero.
//
//   Ports
//     clk    in   1       clock; writes commit on the rising edge
//     rst_n  in   1       asynchronous active-low reset; clears all words
//     we     in   1       write enable, sampled on rising clk
//     a      in   ADDR_W  byte address; word index = a[$clog2(DEPTH)+1:2]
//     wd     in   DATA_W  write data
//     rd     out  DATA_W  read data, combinational from current a
//     err    out  1       misaligned-access flag (only with DMEM_ALIGN_CHECK_EN)
//
//   Build option
//     DMEM_ALIGN_CHECK_EN  when defined, adds err = (a[1:0] != 0) and
//                          suppresses misaligned writes. When undefined,
//                          a[1:0] is ignored and misaligned writes go to
//                          word IDX.
//
//   Address bits above the index are ignored. Accesses therefore wrap modulo
//   DEPTH*4 bytes.
// -----------------------------------------------------------------------------
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              wr_en;

  assign idx = a[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign err   = (a[1:0] != 2'b00);
  assign wr_en = we & ~err;
`else
  // The byte-lane bits take no part in indexing in this build.
  logic unused_lsb;
  assign unused_lsb = ^a[1:0];
  assign wr_en      = we;
`endif

  // Upper address bits are dropped so that addresses alias modulo DEPTH words.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi_unused
      logic unused_hi;
      assign unused_hi = ^a[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  // Reset has priority over a write on the same edge. No write can land
  // while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wd;
    end
  end

  // The read has no write bypass. A same-word write shows up only after the edge.
  assign rd = mem[idx];

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .err  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vector: drive on the falling edge, compare rd (pre-edge contents),
  // then let the next rising edge commit any write.
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    //           we    a           wd            exp_rd        exp_err
    vecs[0]  = '{1'b0, 32'd0,      32'd0,        32'd0,        1'b0};
    vecs[1]  = '{1'b0, 32'd4,      32'd0,        32'd0,        1'b0};
    vecs[2]  = '{1'b0, 32'd252,    32'd0,        32'd0,        1'b0};
    vecs[3]  = '{1'b1, 32'd0,      32'd100,      32'd0,        1'b0};
    vecs[4]  = '{1'b0, 32'd0,      32'd200,      32'd100,      1'b0};
    vecs[5]  = '{1'b1, 32'd4,      32'd200,      32'd0,        1'b0};
    vecs[6]  = '{1'b0, 32'd4,      32'd400,      32'd200,      1'b0};
    vecs[7]  = '{1'b0, 32'd0,      32'd0,        32'd100,      1'b0};
    vecs[8]  = '{1'b1, 32'd0,      32'd400,      32'd100,      1'b0};
    vecs[9]  = '{1'b0, 32'd0,      32'd200,      32'd400,      1'b0};
    vecs[10] = '{1'b0, 32'd3,      32'd0,        32'd400,      1'b1};
    vecs[11] = '{1'b1, 32'd256,    32'd55,       32'd400,      1'b0};
    vecs[12] = '{1'b0, 32'd0,      32'd0,        32'd55,       1'b0};
    vecs[13] = '{1'b0, 32'd4,      32'd0,        32'd200,      1'b0};
    vecs[14] = '{1'b1, 32'd252,    32'hdeadbeef, 32'd0,        1'b0};
    vecs[15] = '{1'b0, 32'd252,    32'd0,        32'hdeadbeef, 1'b0};
    vecs[16] = '{1'b0, 32'h1fc,    32'd0,        32'hdeadbeef, 1'b0};
    vecs[17] = '{1'b1, 32'd6,      32'h1234,     32'd200,      1'b1};
    vecs[18] = '{1'b0, 32'd4,      32'd0,        ALIGN_ON ? 32'd200 : 32'h1234, 1'b0};
    vecs[19] = '{1'b1, 32'd2,      32'd77,       32'd55,       1'b1};
    vecs[20] = '{1'b0, 32'd0,      32'd0,        ALIGN_ON ? 32'd55 : 32'd77,    1'b0};
  end

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    a     = 32'd0;
    wd    = 32'd0;

    // Reset state, with a write attempt held during reset.
    @(negedge clk);
    we = 1'b1; a = 32'd0; wd = 32'hffff_ffff;
    #1 check32("reset_rd", rd, 32'd0);
    @(negedge clk);
    #1 check32("write_blocked_in_reset", rd, 32'd0);
    we = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we = vecs[i].we; a = vecs[i].a; wd = vecs[i].wd;
      #1;
      check32($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
`ifdef DMEM_ALIGN_CHECK_EN
      check32($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
`endif
    end

    // Reset pulse between edges clears the memory immediately.
    @(negedge clk);
    we = 1'b0; a = 32'd0;
    #1 check32("pre_reset_a0", rd, ALIGN_ON ? 32'd55 : 32'd77);
    #1 rst_n = 1'b0;
    #1 check32("mid_reset_a0", rd, 32'd0);
    a = 32'd4;
    #1 check32("mid_reset_a4", rd, 32'd0);
    a = 32'd252;
    #1 check32("mid_reset_a252", rd, 32'd0);

    // Reset held across an edge with a write pending. Reset must win.
    we = 1'b1; a = 32'd8; wd = 32'd99;
    @(posedge clk);
    #1 check32("reset_beats_write", rd, 32'd0);

    // Release reset mid-cycle. The first write happens on the next rising edge.
    #2 rst_n = 1'b1;
    we = 1'b1; a = 32'd8; wd = 32'd321;
    #1 check32("release_before_edge", rd, 32'd0);
    @(posedge clk);
    #1 check32("first_write_after_release", rd, 32'd321);
    we = 1'b0;
    a = 32'd0;
    #1 check32("other_word_still_zero", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
